// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad matrix, debounces presses and
// releases, and hands one 4-bit key code per press to a valid/ready consumer.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r,
    output logic [3:0] c,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       col_next;
    logic [1:0]       row_lat;
    logic [1:0]       row_next;
    logic [1:0]       row_now;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_next;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_next;
    logic             held_next;
    logic             deliver;
    logic             sample;
    logic             pressed;

    assign sample  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign pressed = (r != 4'b1111);

    // Free-running divider that marks one sample edge every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (sample) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Lowest active row wins when several rows are pulled low together.
    always_comb begin
        row_now = 2'd0;
        if (!r[0]) begin
            row_now = 2'd0;
        end else if (!r[1]) begin
            row_now = 2'd1;
        end else if (!r[2]) begin
            row_now = 2'd2;
        end else if (!r[3]) begin
            row_now = 2'd3;
        end
    end

    // Scan/confirm/held decisions, taken only on sample edges.
    always_comb begin
        state_next = state;
        col_next   = col_idx;
        row_next   = row_lat;
        dcnt_next  = dcnt;
        rcnt_next  = rcnt;
        held_next  = key_held;
        deliver    = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (pressed) begin
                        row_next  = row_now;
                        dcnt_next = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            deliver    = 1'b1;
                            held_next  = 1'b1;
                            rcnt_next  = '0;
                            state_next = HELD;
                        end else begin
                            state_next = CONFIRM;
                        end
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (pressed && (row_now == row_lat)) begin
                        dcnt_next = dcnt + CNT_W'(1);
                        if (dcnt_next == CNT_W'(DEBOUNCE)) begin
                            deliver    = 1'b1;
                            held_next  = 1'b1;
                            rcnt_next  = '0;
                            state_next = HELD;
                        end
                    end else begin
                        col_next   = col_idx + 2'd1;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (pressed) begin
                        rcnt_next = '0;
                    end else begin
                        rcnt_next = rcnt + CNT_W'(1);
                        if (rcnt_next == CNT_W'(DEBOUNCE)) begin
                            held_next  = 1'b0;
                            col_next   = col_idx + 2'd1;
                            state_next = SCAN;
                        end
                    end
                end
                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    // Scanner state register, including the registered column drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SCAN;
            col_idx  <= 2'd0;
            c        <= 4'b1110;
            row_lat  <= 2'd0;
            dcnt     <= '0;
            rcnt     <= '0;
            key_held <= 1'b0;
        end else begin
            state    <= state_next;
            col_idx  <= col_next;
            c        <= ~(4'b0001 << col_next);
            row_lat  <= row_next;
            dcnt     <= dcnt_next;
            rcnt     <= rcnt_next;
            key_held <= held_next;
        end
    end

    // Output handshake: a new press loads only if the slot is free or being freed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (deliver && (!key_valid || key_ready)) begin
            key_code  <= {col_idx, row_next};
            key_valid <= 1'b1;
        end else if (deliver) begin
            overrun <= 1'b1;
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, handshake and reset.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    logic       key_on;
    logic [1:0] key_col;
    logic [1:0] key_row;

    int checks_total;
    int checks_passed;
    int edge_n;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .r        (r),
        .c        (c),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overrun  (overrun)
    );

    // Keypad matrix model: the pressed key pulls its row low while its column is driven.
    assign r = (key_on && !c[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, actual, expected, edge_n);
        end
    endtask

    task automatic applyStimulus(input logic on, input logic [1:0] col, input logic [1:0] row);
        key_on  = on;
        key_col = col;
        key_row = row;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    task automatic gotoEdge(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        logic [3:0] exp_c [4];
        exp_c[0] = 4'b1110;
        exp_c[1] = 4'b1101;
        exp_c[2] = 4'b1011;
        exp_c[3] = 4'b0111;
        checks_total  = 0;
        checks_passed = 0;
        edge_n        = 0;
        key_ready     = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0);

        // Idle scan: columns rotate every 4 edges, nothing is reported.
        resetDut();
        #1;
        checkOutput("reset_c", c, 4'b1110);
        checkOutput("reset_valid", key_valid, 1'b0);
        checkOutput("reset_code", key_code, 4'h0);
        checkOutput("reset_held", key_held, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);
        for (int e = 1; e <= 40; e++) begin
            gotoEdge(e);
            checkOutput("idle_c", c, exp_c[(e / 4) % 4]);
            checkOutput("idle_valid", key_valid, 1'b0);
        end

        // Key col 2 / row 1 with consumer always ready.
        key_ready = 1'b1;
        applyStimulus(1'b1, 2'd2, 2'd1);
        resetDut();
        gotoEdge(12);
        checkOutput("press_c_frozen", c, 4'b1011);
        checkOutput("press_valid_12", key_valid, 1'b0);
        gotoEdge(16);
        checkOutput("press_c_16", c, 4'b1011);
        gotoEdge(19);
        checkOutput("press_valid_19", key_valid, 1'b0);
        gotoEdge(20);
        checkOutput("press_valid_20", key_valid, 1'b1);
        checkOutput("press_code_20", key_code, 4'h9);
        checkOutput("press_held_20", key_held, 1'b1);
        gotoEdge(21);
        checkOutput("press_valid_21", key_valid, 1'b0);
        checkOutput("press_held_21", key_held, 1'b1);
        gotoEdge(22);
        applyStimulus(1'b0, 2'd2, 2'd1);
        gotoEdge(31);
        checkOutput("release_held_31", key_held, 1'b1);
        gotoEdge(32);
        checkOutput("release_held_32", key_held, 1'b0);
        checkOutput("release_c_32", c, 4'b0111);
        gotoEdge(36);
        checkOutput("release_c_36", c, 4'b1110);
        checkOutput("release_valid", key_valid, 1'b0);

        // Glitch: key visible for one sample only.
        applyStimulus(1'b1, 2'd2, 2'd1);
        resetDut();
        gotoEdge(12);
        applyStimulus(1'b0, 2'd2, 2'd1);
        gotoEdge(15);
        checkOutput("glitch_c_15", c, 4'b1011);
        gotoEdge(16);
        checkOutput("glitch_c_16", c, 4'b0111);
        for (int e = 17; e <= 28; e++) begin
            gotoEdge(e);
            checkOutput("glitch_valid", key_valid, 1'b0);
        end

        // Backpressure: second press is dropped and flagged.
        key_ready = 1'b0;
        applyStimulus(1'b1, 2'd2, 2'd1);
        resetDut();
        gotoEdge(20);
        checkOutput("bp_valid_20", key_valid, 1'b1);
        checkOutput("bp_code_20", key_code, 4'h9);
        applyStimulus(1'b0, 2'd2, 2'd1);
        gotoEdge(32);
        checkOutput("bp_c_32", c, 4'b0111);
        applyStimulus(1'b1, 2'd3, 2'd3);
        gotoEdge(43);
        checkOutput("bp_overrun_43", overrun, 1'b0);
        gotoEdge(44);
        checkOutput("bp_valid_44", key_valid, 1'b1);
        checkOutput("bp_code_44", key_code, 4'h9);
        checkOutput("bp_overrun_44", overrun, 1'b1);
        checkOutput("bp_held_44", key_held, 1'b1);
        key_ready = 1'b1;
        gotoEdge(45);
        key_ready = 1'b0;
        checkOutput("bp_valid_45", key_valid, 1'b0);
        checkOutput("bp_overrun_45", overrun, 1'b1);

        // Consume and deliver on the same edge.
        applyStimulus(1'b1, 2'd2, 2'd1);
        resetDut();
        gotoEdge(20);
        checkOutput("sim_valid_20", key_valid, 1'b1);
        applyStimulus(1'b0, 2'd2, 2'd1);
        gotoEdge(32);
        applyStimulus(1'b1, 2'd3, 2'd3);
        gotoEdge(43);
        key_ready = 1'b1;
        gotoEdge(44);
        checkOutput("sim_code_44", key_code, 4'hF);
        checkOutput("sim_valid_44", key_valid, 1'b1);
        checkOutput("sim_overrun_44", overrun, 1'b0);
        gotoEdge(45);
        checkOutput("sim_valid_45", key_valid, 1'b0);
        key_ready = 1'b0;

        // Asynchronous reset while a key is held and pending.
        applyStimulus(1'b1, 2'd2, 2'd1);
        resetDut();
        gotoEdge(22);
        checkOutput("rst_pre_valid", key_valid, 1'b1);
        checkOutput("rst_pre_held", key_held, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("rst_c", c, 4'b1110);
        checkOutput("rst_valid", key_valid, 1'b0);
        checkOutput("rst_held", key_held, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_code", key_code, 4'h0);
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
        gotoEdge(4);
        checkOutput("rst_rescan_c_4", c, 4'b1101);
        gotoEdge(12);
        checkOutput("rst_rescan_c_12", c, 4'b1011);
        gotoEdge(20);
        checkOutput("rst_rescan_valid", key_valid, 1'b1);
        checkOutput("rst_rescan_code", key_code, 4'h9);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
